// File: rtl/out_module_if.sv
// Egress port bundle: fabric-side packet input plus the port-side replay burst.
// The switch fabric (or a bench) takes the master view, out_module the slave view.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef DATA_LENGTH_MAX
`define DATA_LENGTH_MAX 64
`endif
`ifndef PRIORITY
`define PRIORITY 4
`endif

interface out_module_if #(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int WP         = $clog2(`PRIORITY)
);
  logic                  in_vld;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  ready_out;
  logic                  rd_sop;
  logic                  rd_eop;
  logic                  rd_vld;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [WP-1:0]         rd_prio;
  logic                  crc_err;

  modport master (
    output in_vld, in_data,
    input  ready_out, rd_sop, rd_eop, rd_vld, rd_data, rd_prio, crc_err
  );

  modport slave (
    input  in_vld, in_data,
    output ready_out, rd_sop, rd_eop, rd_vld, rd_data, rd_prio, crc_err
  );
endinterface

// File: rtl/out_module.sv
// Egress end of a switch port: buffers one packet at a time, checks its CRC-16
// (CCITT polynomial 0x1021, zero init, word MSB first) against the header and
// either replays it as a contiguous burst or drops it with a crc_err pulse.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef DATA_LENGTH_MAX
`define DATA_LENGTH_MAX 64
`endif
`ifndef PRIORITY
`define PRIORITY 4
`endif

module out_module #(
  parameter int num        = 0,
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int FIFO_DEPTH = 256
) (
  input  logic         clk,
  input  logic         rst_n,
  out_module_if.slave  bus
);
  localparam int WL = $clog2(`DATA_LENGTH_MAX);
  localparam int WP = $clog2(`PRIORITY);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_CHECK = 2'd2} w_state_t;
  typedef enum logic {R_IDLE = 1'b0, R_SEND = 1'b1} r_state_t;

  // One 32-bit word through the CRC-16 LFSR, most significant bit first.
  function automatic logic [15:0] crc16_32bit(input logic [15:0] crc_in, input logic [31:0] word);
    logic [15:0] c;
    logic        fb;
    c = crc_in;
    for (int i = 31; i >= 0; i--) begin
      fb = c[15] ^ word[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
      else    c = c;
    end
    return c;
  endfunction

  w_state_t              w_state_r, w_next_s;
  r_state_t              r_state_r, r_next_s;
  logic [WP-1:0]         prio_r;
  logic [15:0]           crc_ref_r;
  logic [WL-1:0]         len_r;
  logic [WL-1:0]         wcnt_r;
  logic [AW-1:0]         wptr_r;
  logic [AW-1:0]         rptr_r;
  logic [15:0]           crc_r;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic                  ready_out_r, rd_sop_r, rd_eop_r, rd_vld_r, crc_err_r;
  logic [DATA_WIDTH-1:0] rd_data_r;
  logic [WP-1:0]         rd_prio_r;

  logic                  hdr_acc_s, wr_en_s, pkt_go_s, crc_bad_s;
  logic                  rd_first_s, rd_load_s, rd_done_s;
  logic [WP-1:0]         hdr_prio_s;
  logic [15:0]           hdr_crc_s;
  logic [WL-1:0]         hdr_len_s;
  logic                  unused_s;

  assign hdr_prio_s = bus.in_data[WP-1:0];
  assign hdr_crc_s  = bus.in_data[WP+15:WP];
  assign hdr_len_s  = bus.in_data[WP+16+WL-1:WP+16];
  assign unused_s   = ^{32'(num)};

  assign bus.ready_out = ready_out_r;
  assign bus.rd_sop    = rd_sop_r;
  assign bus.rd_eop    = rd_eop_r;
  assign bus.rd_vld    = rd_vld_r;
  assign bus.rd_data   = rd_data_r;
  assign bus.rd_prio   = rd_prio_r;
  assign bus.crc_err   = crc_err_r;

  // Write/read FSM state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_r <= W_IDLE;
      r_state_r <= R_IDLE;
    end else begin
      w_state_r <= w_next_s;
      r_state_r <= r_next_s;
    end
  end

  // Write FSM: header accept, payload capture, single-cycle CRC verdict.
  always_comb begin
    w_next_s  = w_state_r;
    hdr_acc_s = 1'b0;
    wr_en_s   = 1'b0;
    pkt_go_s  = 1'b0;
    crc_bad_s = 1'b0;
    case (w_state_r)
      W_IDLE: begin
        if (bus.in_vld && ready_out_r) begin
          hdr_acc_s = 1'b1;
          if (hdr_len_s != {WL{1'b0}}) w_next_s = W_DATA;
          else                         w_next_s = W_IDLE;
        end else begin
          w_next_s = W_IDLE;
        end
      end
      W_DATA: begin
        if (bus.in_vld) begin
          wr_en_s = 1'b1;
          if (WL'(wcnt_r + WL'(1)) == len_r) w_next_s = W_CHECK;
          else                               w_next_s = W_DATA;
        end else begin
          w_next_s = W_DATA;
        end
      end
      W_CHECK: begin
        w_next_s = W_IDLE;
        if (crc_r == crc_ref_r) pkt_go_s  = 1'b1;
        else                    crc_bad_s = 1'b1;
      end
      default: w_next_s = W_IDLE;
    endcase
  end

  // Read FSM: launch the first word on pkt_go, stream, retire after eop.
  always_comb begin
    r_next_s   = r_state_r;
    rd_first_s = 1'b0;
    rd_load_s  = 1'b0;
    rd_done_s  = 1'b0;
    case (r_state_r)
      R_IDLE: begin
        if (pkt_go_s) begin
          r_next_s   = R_SEND;
          rd_first_s = 1'b1;
        end else begin
          r_next_s = R_IDLE;
        end
      end
      R_SEND: begin
        if (rd_eop_r) begin
          r_next_s  = R_IDLE;
          rd_done_s = 1'b1;
        end else begin
          r_next_s  = R_SEND;
          rd_load_s = 1'b1;
        end
      end
      default: r_next_s = R_IDLE;
    endcase
  end

  // Header fields and write-side counters; pointers rewind at the verdict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_r    <= {WP{1'b0}};
      crc_ref_r <= 16'h0000;
      len_r     <= {WL{1'b0}};
      wcnt_r    <= {WL{1'b0}};
      wptr_r    <= {AW{1'b0}};
    end else if (hdr_acc_s) begin
      prio_r    <= hdr_prio_s;
      crc_ref_r <= hdr_crc_s;
      len_r     <= hdr_len_s;
      wcnt_r    <= {WL{1'b0}};
      wptr_r    <= {AW{1'b0}};
    end else if (wr_en_s) begin
      wcnt_r    <= wcnt_r + WL'(1);
      wptr_r    <= wptr_r + AW'(1);
    end else if (w_state_r == W_CHECK) begin
      wcnt_r    <= {WL{1'b0}};
      wptr_r    <= {AW{1'b0}};
    end else begin
      wcnt_r    <= wcnt_r;
      wptr_r    <= wptr_r;
    end
  end

  // Running payload CRC, held at zero whenever no packet is being received.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   crc_r <= 16'h0000;
    else if (w_state_r == W_IDLE) crc_r <= 16'h0000;
    else if (wr_en_s)             crc_r <= crc16_32bit(crc_r, bus.in_data[31:0]);
    else                          crc_r <= crc_r;
  end

  // Payload buffer storage; contents need no reset since pointers gate reads.
  always_ff @(posedge clk) begin
    if (wr_en_s) mem[wptr_r] <= bus.in_data;
  end

  // Registered burst outputs; rd_data/rd_prio hold their last value when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_r  <= 1'b0;
      rd_sop_r  <= 1'b0;
      rd_eop_r  <= 1'b0;
      rd_data_r <= {DATA_WIDTH{1'b0}};
      rd_prio_r <= {WP{1'b0}};
      rptr_r    <= {AW{1'b0}};
    end else if (rd_first_s || rd_load_s) begin
      rd_vld_r  <= 1'b1;
      rd_sop_r  <= rd_first_s;
      rd_eop_r  <= (rptr_r == (AW'(len_r) - AW'(1)));
      rd_data_r <= mem[rptr_r];
      rptr_r    <= rptr_r + AW'(1);
      if (rd_first_s) rd_prio_r <= prio_r;
      else            rd_prio_r <= rd_prio_r;
    end else begin
      rd_vld_r  <= 1'b0;
      rd_sop_r  <= 1'b0;
      rd_eop_r  <= 1'b0;
      if (rd_done_s) rptr_r <= {AW{1'b0}};
      else           rptr_r <= rptr_r;
    end
  end

  // Status: drop pulse one cycle after the verdict, ready only when fully idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_err_r   <= 1'b0;
      ready_out_r <= 1'b0;
    end else begin
      crc_err_r   <= crc_bad_s;
      ready_out_r <= (w_next_s == W_IDLE) && (r_next_s == R_IDLE);
    end
  end
endmodule

// File: tb/tb_out_module.sv
// Directed bench for out_module: good/bad/gapped/short/empty packets,
// mid-packet reset and back-to-back traffic, with a local CRC-16 model.
module tb_out_module;
  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;
  logic [31:0] pl [16];

  out_module_if #(.DATA_WIDTH(32), .WP(2)) bus ();

  out_module #(.num(0), .DATA_WIDTH(32), .FIFO_DEPTH(256)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Polynomial long division: (crc * x^32 + word * x^16) mod 0x11021.
  function automatic logic [15:0] crc_model(input logic [15:0] c, input logic [31:0] d);
    logic [47:0] v;
    v = {c, 32'h0000_0000} ^ {d, 16'h0000};
    for (int i = 47; i >= 16; i--) begin
      if (v[i]) v = v ^ (48'h0000_0001_1021 << (i - 16));
    end
    return v[15:0];
  endfunction

  function automatic logic [15:0] pkt_crc(input int n);
    logic [15:0] c;
    c = 16'h0000;
    for (int i = 0; i < n; i++) c = crc_model(c, pl[i]);
    return c;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_hdr(input logic [1:0] p, input logic [15:0] c, input logic [5:0] l);
    int waited;
    waited = 0;
    while (bus.ready_out !== 1'b1 && waited < 64) begin
      step();
      waited++;
    end
    if (waited >= 64) check_val("hdr_ready_timeout", 32'd0, 32'd1);
    bus.in_vld  = 1'b1;
    bus.in_data = {8'h00, l, c, p};
    step();
    bus.in_vld  = 1'b0;
  endtask

  task automatic send_payload(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) step();
      end
      bus.in_vld  = 1'b1;
      bus.in_data = pl[i];
      step();
      bus.in_vld  = 1'b0;
    end
  endtask

  // Called right after the last payload word was clocked in (cycle L+1).
  task automatic expect_good(input int n, input logic [1:0] p, input bit junk);
    check_val("chk_cycle_vld", 32'(bus.rd_vld), 32'd0);
    check_val("chk_cycle_ready", 32'(bus.ready_out), 32'd0);
    if (junk) begin
      bus.in_vld  = 1'b1;
      bus.in_data = {8'h00, 6'd2, 16'h1234, 2'd1};
    end
    for (int k = 0; k < n; k++) begin
      step();
      check_val("burst_vld", 32'(bus.rd_vld), 32'd1);
      check_val("burst_sop", 32'(bus.rd_sop), 32'(k == 0));
      check_val("burst_eop", 32'(bus.rd_eop), 32'(k == n - 1));
      check_val("burst_data", bus.rd_data, pl[k]);
      check_val("burst_prio", 32'(bus.rd_prio), 32'(p));
      check_val("burst_crc_err", 32'(bus.crc_err), 32'd0);
    end
    step();
    bus.in_vld = 1'b0;
    check_val("post_eop_vld", 32'(bus.rd_vld), 32'd0);
    check_val("post_eop_ready", 32'(bus.ready_out), 32'd1);
  endtask

  task automatic expect_bad();
    check_val("bad_check_err", 32'(bus.crc_err), 32'd0);
    step();
    check_val("bad_err_pulse", 32'(bus.crc_err), 32'd1);
    check_val("bad_ready", 32'(bus.ready_out), 32'd1);
    check_val("bad_no_vld", 32'(bus.rd_vld), 32'd0);
    step();
    check_val("bad_err_drop", 32'(bus.crc_err), 32'd0);
    check_val("bad_no_vld2", 32'(bus.rd_vld), 32'd0);
  endtask

  task automatic run_good(input int n, input logic [1:0] p, input int gap, input bit junk);
    send_hdr(p, pkt_crc(n), 6'(n));
    check_val("hdr_ready_low", 32'(bus.ready_out), 32'd0);
    send_payload(n, gap);
    expect_good(n, p, junk);
  endtask

  initial begin
    logic [15:0] c;
    int          vld_seen;
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    bus.in_vld   = 1'b0;
    bus.in_data  = 32'h0000_0000;

    // Reset state
    step();
    step();
    check_val("rst_ready", 32'(bus.ready_out), 32'd0);
    check_val("rst_vld", 32'(bus.rd_vld), 32'd0);
    check_val("rst_sop_eop", {30'd0, bus.rd_sop, bus.rd_eop}, 32'd0);
    check_val("rst_data", bus.rd_data, 32'd0);
    check_val("rst_prio_err", {29'd0, bus.rd_prio, bus.crc_err}, 32'd0);
    rst_n = 1'b1;
    check_val("rel_ready_before_edge", 32'(bus.ready_out), 32'd0);
    step();
    check_val("rel_ready_first_edge", 32'(bus.ready_out), 32'd1);
    check_val("rel_vld", 32'(bus.rd_vld), 32'd0);

    // len=4 good packet, prio 2, junk in_vld during burst must be ignored
    pl[0] = 32'h1111_1111; pl[1] = 32'h2222_2222;
    pl[2] = 32'h3333_3333; pl[3] = 32'h4444_4444;
    run_good(4, 2'd2, 0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      check_val("junk_ignored_vld", 32'(bus.rd_vld), 32'd0);
    end
    check_val("junk_ignored_ready", 32'(bus.ready_out), 32'd1);

    // Same packet with bit 0 of word 2 flipped, header CRC of the good data
    c = pkt_crc(4);
    pl[2] = pl[2] ^ 32'h0000_0001;
    send_hdr(2'd2, c, 6'd4);
    send_payload(4, 0);
    expect_bad();
    pl[2] = 32'h3333_3333;

    // Following good packet passes intact
    run_good(4, 2'd2, 0, 1'b0);

    // len=3 with 2-cycle gaps between words
    pl[0] = 32'hDEAD_BEEF; pl[1] = 32'h0123_4567; pl[2] = 32'hFFFF_0000;
    run_good(3, 2'd1, 2, 1'b0);

    // len=1: sop and eop together
    pl[0] = 32'hA5A5_A5A5;
    run_good(1, 2'd3, 0, 1'b0);

    // len=0 header: consumed, nothing output
    send_hdr(2'd1, 16'hBEEF, 6'd0);
    check_val("len0_ready", 32'(bus.ready_out), 32'd1);
    vld_seen = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus.rd_vld === 1'b1) vld_seen++;
    end
    check_val("len0_no_output", 32'(vld_seen), 32'd0);

    // Reset pulsed during payload of a len=8 packet
    for (int i = 0; i < 8; i++) pl[i] = 32'h0101_0101 * (i + 1);
    send_hdr(2'd0, pkt_crc(8), 6'd8);
    send_payload(3, 0);
    #2 rst_n = 1'b0;
    #1;
    check_val("midrst_ready", 32'(bus.ready_out), 32'd0);
    check_val("midrst_vld", 32'(bus.rd_vld), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    check_val("midrst_ready_after", 32'(bus.ready_out), 32'd1);
    vld_seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.rd_vld === 1'b1) vld_seen++;
    end
    check_val("midrst_no_output", 32'(vld_seen), 32'd0);

    // Back-to-back packets, second header waits on ready_out
    pl[0] = 32'hCAFE_0001; pl[1] = 32'hCAFE_0002;
    run_good(2, 2'd0, 0, 1'b0);
    pl[0] = 32'hBEEF_0001; pl[1] = 32'hBEEF_0002;
    run_good(2, 2'd3, 0, 1'b0);
    step();
    check_val("final_idle_vld", 32'(bus.rd_vld), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
